// File: rtl/seg7_multi_digit_driver.sv
// Multi-digit 7-segment driver: binary value -> DIGITS decimal digits via a
// sequential double-dabble engine, or raw hex nibbles, encoded to segments.
// Ports: clk, reset (async, active-high); value/hex_mode/load request a new
// display; busy/done/overflow report status; hex_out carries 7 bits per
// digit as {g,f,e,d,c,b,a}, with digit 0 in the least significant bits.
module seg7_multi_digit_driver #(
  parameter int DIGITS        = 6,
  parameter int BIN_WIDTH     = 20,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BIN_WIDTH-1:0]   value,
  input  logic                   hex_mode,
  input  logic                   load,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [7*DIGITS-1:0]    hex_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest value that fits in DIGITS decimal digits.
  localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

  localparam logic [6:0] SEG_DASH   = 7'b1000000;
  localparam logic [6:0] SEG_BLANK  = 7'b0000000;
  localparam logic [6:0] HEX_OFF7   = ACTIVE_LOW ? 7'h7F : 7'h00;

  // Active-high gfedcba pattern for one nibble. In decimal mode a nibble
  // of 10..15 is impossible, so it is shown as a dash.
  function automatic logic [6:0] seg_enc(input logic [3:0] n, input logic hex);
    logic [6:0] s;
    case (n)
      4'd0:  s = 7'b0111111;
      4'd1:  s = 7'b0000110;
      4'd2:  s = 7'b1011011;
      4'd3:  s = 7'b1001111;
      4'd4:  s = 7'b1100110;
      4'd5:  s = 7'b1101101;
      4'd6:  s = 7'b1111101;
      4'd7:  s = 7'b0000111;
      4'd8:  s = 7'b1111111;
      4'd9:  s = 7'b1101111;
      4'd10: s = hex ? 7'b1110111 : SEG_DASH;
      4'd11: s = hex ? 7'b1111100 : SEG_DASH;
      4'd12: s = hex ? 7'b0111001 : SEG_DASH;
      4'd13: s = hex ? 7'b1011110 : SEG_DASH;
      4'd14: s = hex ? 7'b1111001 : SEG_DASH;
      default: s = hex ? 7'b1110001 : SEG_DASH;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hex_q, hex_d;
  logic                ovf_cap_q, ovf_cap_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [7*DIGITS-1:0] hex_out_q, hex_out_d;

  // Overflow is decided from the captured value, before any shifting.
  logic [63:0] value_ext;
  logic        dec_ovf, hex_ovf;
  assign value_ext = 64'(value);
  assign dec_ovf   = (value_ext > DEC_MAX);
  assign hex_ovf   = |(value_ext >> BCD_W);

  // One double-dabble step: correct every BCD nibble >= 5, then shift.
  logic [SR_W-1:0] sr_step;
  always_comb begin
    sr_step = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[BIN_WIDTH+4*i +: 4] >= 4'd5)
        sr_step[BIN_WIDTH+4*i +: 4] = sr_q[BIN_WIDTH+4*i +: 4] + 4'd3;
    end
    sr_step = sr_step << 1;
  end

  // Digits to encode: BCD part after conversion, or the raw low nibbles.
  logic [63:0]      bin_ext;
  logic [BCD_W-1:0] digits;
  assign bin_ext = 64'(sr_q[BIN_WIDTH-1:0]);
  assign digits  = hex_q ? bin_ext[BCD_W-1:0] : sr_q[SR_W-1:BIN_WIDTH];

  // Encode from the most significant digit down so 'lead' tracks whether
  // every digit above (and including) this one is zero.
  logic [7*DIGITS-1:0] enc;
  logic                lead;
  logic [6:0]          seg;
  always_comb begin
    enc  = '0;
    lead = 1'b1;
    seg  = SEG_BLANK;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (digits[4*i +: 4] != 4'd0) lead = 1'b0;
      if (ovf_cap_q)
        seg = SEG_DASH;
      else if (BLANK_LEADING && lead && (i != 0))
        seg = SEG_BLANK;
      else
        seg = seg_enc(digits[4*i +: 4], hex_q);
      enc[7*i +: 7] = ACTIVE_LOW ? ~seg : seg;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    hex_d     = hex_q;
    ovf_cap_d = ovf_cap_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    hex_out_d = hex_out_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d      = {{BCD_W{1'b0}}, value};
          cnt_d     = '0;
          hex_d     = hex_mode;
          ovf_cap_d = hex_mode ? hex_ovf : dec_ovf;
          state_d   = hex_mode ? UPDATE : SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        hex_out_d = enc;
        ovf_d     = ovf_cap_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      hex_q     <= 1'b0;
      ovf_cap_q <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      hex_out_q <= {DIGITS{HEX_OFF7}};
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      ovf_cap_q <= ovf_cap_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      hex_out_q <= hex_out_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign hex_out  = hex_out_q;

endmodule

// File: tb/tb_seg7_multi_digit_driver.sv
// Directed bench for seg7_multi_digit_driver: default instance (6 digits,
// 20-bit, active-low) plus a 4-digit/16-bit active-high instance.
module tb_seg7_multi_digit_driver;

  // Active-high gfedcba patterns
  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
  localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S9 = 7'h6F;
  localparam logic [6:0] SA = 7'h77, SB = 7'h7C, SC = 7'h39, SD = 7'h5E, SE = 7'h79;
  localparam logic [6:0] DASH = 7'h40;
  localparam logic [6:0] OFF = 7'h7F;   // all-off, active-low
  localparam logic [6:0] DL  = ~DASH;   // dash, active-low

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] value = '0;
  logic        hex_mode = 1'b0, load = 1'b0;
  logic        busy, done, overflow;
  logic [41:0] hex_out;

  logic [15:0] value2 = '0;
  logic        hex_mode2 = 1'b0, load2 = 1'b0;
  logic        busy2, done2, ovf2;
  logic [27:0] hex_out2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_multi_digit_driver dut (
    .clk(clk), .reset(rst), .value(value), .hex_mode(hex_mode), .load(load),
    .busy(busy), .done(done), .overflow(overflow), .hex_out(hex_out)
  );

  seg7_multi_digit_driver #(.DIGITS(4), .BIN_WIDTH(16), .ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) dut2 (
    .clk(clk), .reset(rst), .value(value2), .hex_mode(hex_mode2), .load(load2),
    .busy(busy2), .done(done2), .overflow(ovf2), .hex_out(hex_out2)
  );

  // Negedges until done is seen, -1 if not within 100 cycles.
  task automatic wait_done(input bit sel, output int c);
    c = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if ((sel ? done2 : done) === 1'b1) begin
        c = i;
        break;
      end
    end
  endtask

  // Single-cycle load pulse; returns at the negedge after the capture edge.
  task automatic start(input logic [19:0] v, input logic hm);
    @(negedge clk);
    value = v; hex_mode = hm; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic start2(input logic [15:0] v);
    @(negedge clk);
    value2 = v; hex_mode2 = 1'b0; load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++; if (hex_out !== {6{OFF}}) begin n_fail++; $display("FAIL reset_hex_out: got %h expected %h", hex_out, {6{OFF}}); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_tests++; if (hex_out2 !== 28'h0) begin n_fail++; $display("FAIL reset_hex_out2: got %h expected 0", hex_out2); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (hex_out !== {6{OFF}} || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL after_release: hex_out %h busy %b done %b expected %h 0 0", hex_out, busy, done, {6{OFF}});
    end
  endtask

  task automatic test_decimal_latency;
    logic [41:0] exp_h;
    int bad;
    exp_h = {~S1, ~S2, ~S3, ~S4, ~S5, ~S6};
    bad = 0;
    start(20'd123456, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy_start: got %b expected 1", busy); end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0 || hex_out !== {6{OFF}}) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL lat_busy_window: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL lat_done: got %b expected 1", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lat_busy_end: got %b expected 0", busy); end
    n_tests++; if (hex_out !== exp_h) begin n_fail++; $display("FAIL dec_123456: got %h expected %h", hex_out, exp_h); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL dec_123456_ovf: got %b expected 0", overflow); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0 || hex_out !== exp_h) begin
      n_fail++; $display("FAIL done_pulse_hold: done %b hex_out %h expected 0 %h", done, hex_out, exp_h);
    end
  endtask

  task automatic test_blanking;
    int c;
    start(20'd7, 1'b0);
    wait_done(1'b0, c);
    n_tests++; if (c != 21) begin n_fail++; $display("FAIL blank7_latency: got %0d expected 21", c); end
    n_tests++; if (hex_out !== {OFF, OFF, OFF, OFF, OFF, ~S7}) begin
      n_fail++; $display("FAIL blank7: got %h expected %h", hex_out, {OFF, OFF, OFF, OFF, OFF, ~S7});
    end
    start(20'd0, 1'b0);
    wait_done(1'b0, c);
    n_tests++; if (hex_out !== {OFF, OFF, OFF, OFF, OFF, ~S0}) begin
      n_fail++; $display("FAIL blank0: got %h expected %h", hex_out, {OFF, OFF, OFF, OFF, OFF, ~S0});
    end
  endtask

  task automatic test_hex;
    int c;
    start(20'hABCDE, 1'b1);
    wait_done(1'b0, c);
    n_tests++; if (c != 1) begin n_fail++; $display("FAIL hex_latency: got %0d expected 1", c); end
    n_tests++; if (hex_out !== {OFF, ~SA, ~SB, ~SC, ~SD, ~SE}) begin
      n_fail++; $display("FAIL hex_abcde: got %h expected %h", hex_out, {OFF, ~SA, ~SB, ~SC, ~SD, ~SE});
    end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL hex_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow;
    int c;
    start(20'd1000000, 1'b0);
    wait_done(1'b0, c);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_tests++; if (hex_out !== {6{DL}}) begin n_fail++; $display("FAIL ovf_dashes: got %h expected %h", hex_out, {6{DL}}); end
  endtask

  task automatic test_reset_mid_shift;
    int c;
    start(20'd555, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || hex_out !== {6{OFF}}) begin
      n_fail++; $display("FAIL mid_reset: busy %b done %b ovf %b hex_out %h expected 0 0 0 %h", busy, done, overflow, hex_out, {6{OFF}});
    end
    @(negedge clk);
    rst = 1'b0;
    wait_done(1'b0, c);
    n_tests++; if (c != -1) begin n_fail++; $display("FAIL mid_reset_no_done: got done at %0d expected none", c); end
  endtask

  task automatic test_ignore_busy;
    int c;
    start(20'd123, 1'b0);
    repeat (4) @(negedge clk);
    value = 20'd999; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_done(1'b0, c);
    n_tests++; if (c != 16) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 16", c); end
    n_tests++; if (hex_out !== {OFF, OFF, OFF, ~S1, ~S2, ~S3}) begin
      n_fail++; $display("FAIL ignore_value: got %h expected %h", hex_out, {OFF, OFF, OFF, ~S1, ~S2, ~S3});
    end
    wait_done(1'b0, c);
    n_tests++; if (c != -1) begin n_fail++; $display("FAIL ignore_extra_done: got done at %0d expected none", c); end
  endtask

  task automatic test_back_to_back;
    int c1, c2, c3;
    @(negedge clk);
    value = 20'd42; hex_mode = 1'b0; load = 1'b1;
    wait_done(1'b0, c1);
    n_tests++; if (c1 != 22) begin n_fail++; $display("FAIL held_first: got %0d expected 22", c1); end
    wait_done(1'b0, c2);
    load = 1'b0;
    n_tests++; if (c2 != 22) begin n_fail++; $display("FAIL held_period: got %0d expected 22", c2); end
    n_tests++; if (hex_out !== {OFF, OFF, OFF, OFF, ~S4, ~S2}) begin
      n_fail++; $display("FAIL held_value: got %h expected %h", hex_out, {OFF, OFF, OFF, OFF, ~S4, ~S2});
    end
    wait_done(1'b0, c3);
    n_tests++; if (c3 != -1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL held_release: done at %0d busy %b expected none 0", c3, busy);
    end
  endtask

  task automatic test_param_sweep;
    int c;
    start2(16'd9999);
    wait_done(1'b1, c);
    n_tests++; if (c != 17) begin n_fail++; $display("FAIL sweep_latency: got %0d expected 17", c); end
    n_tests++; if (hex_out2 !== {4{S9}} || ovf2 !== 1'b0) begin
      n_fail++; $display("FAIL sweep_9999: got %h ovf %b expected %h 0", hex_out2, ovf2, {4{S9}});
    end
    start2(16'd10000);
    wait_done(1'b1, c);
    n_tests++; if (hex_out2 !== {4{DASH}} || ovf2 !== 1'b1) begin
      n_fail++; $display("FAIL sweep_10000: got %h ovf %b expected %h 1", hex_out2, ovf2, {4{DASH}});
    end
  endtask

  initial begin
    test_reset();
    test_decimal_latency();
    test_blanking();
    test_hex();
    test_overflow();
    test_reset_mid_shift();
    test_ignore_busy();
    test_back_to_back();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
